dmac_mc: RTL and testbench

- Multi-channel successor to the single-channel DMA shim.
- Accepts independent read and write requests from NUM_CH user channels and queues one pending request per channel per direction.
- Arbitrates round-robin onto the single host DMA interface. Read and write engines run independently.
- Adds a base-address offset, per-channel busy/error status, and data-path steering to the granted channel.

---
 rtl/dmac_mc_pkg.sv | 7 +
 rtl/dmac_rr_arb.sv | 26 ++
 rtl/dmac_mc.sv | 139 +++++++++++++
 tb/tb_dmac_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_mc_pkg.sv
// dmac_mc_pkg: shared engine state encoding and round-robin index helper
package dmac_mc_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} eng_state_e;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/dmac_rr_arb.sv
// dmac_rr_arb: combinational round-robin pick starting after last_grant
module dmac_rr_arb
  import dmac_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              valid
);
  logic [CH_W-1:0] c;
  always_comb begin
    valid = 1'b0;
    grant_idx = '0;
    c = last_grant;
    for (int k = 0; k < NUM_CH; k++) begin
      c = CH_W'(rr_next(int'(c), NUM_CH));
      if (!valid && pending[c]) begin
        valid = 1'b1;
        grant_idx = c;
      end
    end
  end
endmodule

// File: rtl/dmac_mc.sv
// dmac_mc: multi-channel DMA front end, round-robin read and write engines onto one host port
module dmac_mc
  import dmac_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [NUM_CH-1:0]            ch_rd_go,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_rd_addr,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] ch_rd_size,
  input  logic [NUM_CH-1:0]            ch_rd_en,
  output logic [DATA_WIDTH-1:0]        ch_rd_data,
  output logic [NUM_CH-1:0]            ch_empty,
  output logic [NUM_CH-1:0]            ch_rd_busy,
  output logic [NUM_CH-1:0]            ch_rd_done,
  output logic [NUM_CH-1:0]            ch_rd_err,
  input  logic [NUM_CH-1:0]            ch_wr_go,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_wr_addr,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] ch_wr_size,
  input  logic [NUM_CH-1:0]            ch_wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]            ch_full,
  output logic [NUM_CH-1:0]            ch_wr_busy,
  output logic [NUM_CH-1:0]            ch_wr_done,
  output logic [NUM_CH-1:0]            ch_wr_err,
  output logic                         dma_rd_go,
  output logic [ADDR_WIDTH-1:0]        dma_rd_addr,
  output logic [SIZE_WIDTH-1:0]        dma_rd_size,
  input  logic [DATA_WIDTH-1:0]        dma_rd_data,
  input  logic                         dma_empty,
  output logic                         dma_rd_en,
  input  logic                         dma_rd_done,
  output logic                         dma_wr_go,
  output logic [ADDR_WIDTH-1:0]        dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]        dma_wr_size,
  output logic [DATA_WIDTH-1:0]        dma_wr_data,
  input  logic                         dma_full,
  output logic                         dma_wr_en,
  input  logic                         dma_wr_done
);
  eng_state_e rd_st, rd_st_n, wr_st, wr_st_n;
  logic [CH_W-1:0] rd_g, rd_last, rd_idx, wr_g, wr_last, wr_idx;
  logic rd_valid, wr_valid;
  logic [NUM_CH-1:0] rd_pend, rd_acc, rd_err, rd_oh, wr_pend, wr_acc, wr_err, wr_oh;
  logic [ADDR_WIDTH-1:0] rd_addr_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] wr_addr_q [NUM_CH];
  logic [SIZE_WIDTH-1:0] rd_size_q [NUM_CH];
  logic [SIZE_WIDTH-1:0] wr_size_q [NUM_CH];
  dmac_rr_arb #(.NUM_CH(NUM_CH)) u_rd_arb (.pending(rd_pend), .last_grant(rd_last), .grant_idx(rd_idx), .valid(rd_valid));
  dmac_rr_arb #(.NUM_CH(NUM_CH)) u_wr_arb (.pending(wr_pend), .last_grant(wr_last), .grant_idx(wr_idx), .valid(wr_valid));
  always_comb begin
    rd_st_n = rd_st == IDLE ? (rd_valid ? ISSUE : IDLE) :
              rd_st == ISSUE ? ACTIVE :
              rd_st == ACTIVE ? (dma_rd_done ? DONE : ACTIVE) : IDLE;
    for (int i = 0; i < NUM_CH; i++)
      rd_acc[i] = ch_rd_go[i] & ~rd_pend[i] & (ch_rd_size[i*SIZE_WIDTH +: SIZE_WIDTH] != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st <= IDLE;
      rd_pend <= '0;
      rd_err <= '0;
      rd_g <= '0;
      rd_last <= CH_W'(NUM_CH - 1);
      dma_rd_addr <= '0;
      dma_rd_size <= '0;
    end else begin
      rd_st <= rd_st_n;
      rd_err <= ch_rd_go & ~rd_acc;
      rd_pend <= (rd_pend & ~(rd_st == DONE ? rd_oh : '0)) | rd_acc;
      if (rd_st == IDLE && rd_valid) begin
        rd_g <= rd_idx;
        dma_rd_addr <= base_addr + rd_addr_q[rd_idx];
        dma_rd_size <= rd_size_q[rd_idx];
      end
      if (rd_st == DONE) rd_last <= rd_g;
      for (int i = 0; i < NUM_CH; i++)
        if (rd_acc[i]) begin
          rd_addr_q[i] <= ch_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          rd_size_q[i] <= ch_rd_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        end
    end
  end
  assign rd_oh = NUM_CH'(1) << rd_g;
  assign dma_rd_go = rd_st == ISSUE;
  assign dma_rd_en = rd_st == ACTIVE && ch_rd_en[rd_g] && !dma_empty;
  assign ch_rd_data = rd_st == ACTIVE ? dma_rd_data : '0;
  assign ch_empty = rd_st == ACTIVE ? (~rd_oh | {NUM_CH{dma_empty}}) : '1;
  assign ch_rd_busy = rd_pend;
  assign ch_rd_done = rd_st == DONE ? rd_oh : '0;
  assign ch_rd_err = rd_err;
  always_comb begin
    wr_st_n = wr_st == IDLE ? (wr_valid ? ISSUE : IDLE) :
              wr_st == ISSUE ? ACTIVE :
              wr_st == ACTIVE ? (dma_wr_done ? DONE : ACTIVE) : IDLE;
    for (int i = 0; i < NUM_CH; i++)
      wr_acc[i] = ch_wr_go[i] & ~wr_pend[i] & (ch_wr_size[i*SIZE_WIDTH +: SIZE_WIDTH] != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st <= IDLE;
      wr_pend <= '0;
      wr_err <= '0;
      wr_g <= '0;
      wr_last <= CH_W'(NUM_CH - 1);
      dma_wr_addr <= '0;
      dma_wr_size <= '0;
    end else begin
      wr_st <= wr_st_n;
      wr_err <= ch_wr_go & ~wr_acc;
      wr_pend <= (wr_pend & ~(wr_st == DONE ? wr_oh : '0)) | wr_acc;
      if (wr_st == IDLE && wr_valid) begin
        wr_g <= wr_idx;
        dma_wr_addr <= base_addr + wr_addr_q[wr_idx];
        dma_wr_size <= wr_size_q[wr_idx];
      end
      if (wr_st == DONE) wr_last <= wr_g;
      for (int i = 0; i < NUM_CH; i++)
        if (wr_acc[i]) begin
          wr_addr_q[i] <= ch_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          wr_size_q[i] <= ch_wr_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        end
    end
  end
  assign wr_oh = NUM_CH'(1) << wr_g;
  assign dma_wr_go = wr_st == ISSUE;
  assign dma_wr_en = wr_st == ACTIVE && ch_wr_en[wr_g] && !dma_full;
  assign dma_wr_data = wr_st == ACTIVE ? ch_wr_data[wr_g*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ch_full = wr_st == ACTIVE ? (~wr_oh | {NUM_CH{dma_full}}) : '1;
  assign ch_wr_busy = wr_pend;
  assign ch_wr_done = wr_st == DONE ? wr_oh : '0;
  assign ch_wr_err = wr_err;
endmodule

// File: tb/tb_dmac_mc.sv
// tb_dmac_mc: directed checks of acceptance, round-robin order, steering and reset
module tb_dmac_mc;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] base_addr;
  logic [3:0] ch_rd_go, ch_rd_en, ch_empty, ch_rd_busy, ch_rd_done, ch_rd_err;
  logic [127:0] ch_rd_addr, ch_wr_addr, ch_wr_data;
  logic [63:0] ch_rd_size, ch_wr_size;
  logic [31:0] ch_rd_data;
  logic [3:0] ch_wr_go, ch_wr_en, ch_full, ch_wr_busy, ch_wr_done, ch_wr_err;
  logic dma_rd_go, dma_empty, dma_rd_en, dma_rd_done;
  logic [31:0] dma_rd_addr, dma_rd_data;
  logic [15:0] dma_rd_size, dma_wr_size;
  logic dma_wr_go, dma_full, dma_wr_en, dma_wr_done;
  logic [31:0] dma_wr_addr, dma_wr_data;
  int total = 0, passed = 0, gos;

  dmac_mc dut (
    .clk(clk), .rst(rst), .base_addr(base_addr),
    .ch_rd_go(ch_rd_go), .ch_rd_addr(ch_rd_addr), .ch_rd_size(ch_rd_size), .ch_rd_en(ch_rd_en),
    .ch_rd_data(ch_rd_data), .ch_empty(ch_empty), .ch_rd_busy(ch_rd_busy), .ch_rd_done(ch_rd_done),
    .ch_rd_err(ch_rd_err),
    .ch_wr_go(ch_wr_go), .ch_wr_addr(ch_wr_addr), .ch_wr_size(ch_wr_size), .ch_wr_en(ch_wr_en),
    .ch_wr_data(ch_wr_data), .ch_full(ch_full), .ch_wr_busy(ch_wr_busy), .ch_wr_done(ch_wr_done),
    .ch_wr_err(ch_wr_err),
    .dma_rd_go(dma_rd_go), .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size),
    .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_rd_en(dma_rd_en), .dma_rd_done(dma_rd_done),
    .dma_wr_go(dma_wr_go), .dma_wr_addr(dma_wr_addr), .dma_wr_size(dma_wr_size),
    .dma_wr_data(dma_wr_data), .dma_full(dma_full), .dma_wr_en(dma_wr_en), .dma_wr_done(dma_wr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // waits (bounded) for a host read start, checks it, then completes that transfer
  task automatic serve_rd(input string tag, input logic [31:0] a, input logic [3:0] m);
    int n = 0;
    while (!dma_rd_go && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_go"}, 64'(dma_rd_go), 64'd1);
    chk({tag, "_addr"}, 64'(dma_rd_addr), 64'(a));
    tick();
    dma_rd_done = 1'b1;
    #1;
    tick();
    dma_rd_done = 1'b0;
    #1;
    chk({tag, "_done"}, 64'(ch_rd_done), 64'(m));
    tick();
  endtask

  task automatic count_gos(input int cycles);
    gos = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (dma_rd_go) gos++;
    end
  endtask

  initial begin
    rst = 1'b1;
    base_addr = 32'h1000;
    ch_rd_go = '0; ch_rd_en = '0; ch_wr_go = '0; ch_wr_en = '0;
    ch_rd_addr = {32'h40, 32'h30, 32'h40, 32'h10};
    ch_wr_addr = {32'h0, 32'h0, 32'h0, 32'h20};
    ch_rd_size = {4{16'd8}};
    ch_wr_size = {4{16'd4}};
    ch_wr_data = '0;
    dma_rd_data = '0; dma_empty = 1'b1; dma_rd_done = 1'b0;
    dma_full = 1'b1; dma_wr_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", 64'(ch_empty), 64'hF);
    chk("rst_full", 64'(ch_full), 64'hF);
    chk("rst_busy", 64'({ch_rd_busy, ch_wr_busy}), 64'h0);
    chk("rst_go", 64'({dma_rd_go, dma_wr_go}), 64'h0);
    chk("rst_rd_addr", 64'(dma_rd_addr), 64'h0);
    // simultaneous gos served 0,2,3; a late ch0 go waits behind ch3
    ch_rd_go = 4'b1101;
    tick();
    ch_rd_go = '0;
    #1;
    chk("rr_busy", 64'(ch_rd_busy), 64'hD);
    serve_rd("rr0", 32'h1010, 4'b0001);
    serve_rd("rr2", 32'h1030, 4'b0100);
    tick();
    chk("rr3_go", 64'(dma_rd_go), 64'd1);
    chk("rr3_addr", 64'(dma_rd_addr), 64'h1040);
    tick();
    ch_rd_go = 4'b0001;
    tick();
    ch_rd_go = '0;
    dma_rd_done = 1'b1;
    #1;
    tick();
    dma_rd_done = 1'b0;
    #1;
    chk("rr3_done", 64'(ch_rd_done), 64'h8);
    tick();
    serve_rd("rr0b", 32'h1010, 4'b0001);
    // single read on ch1 with exact latency, then steering in ACTIVE
    ch_rd_go = 4'b0010;
    #1;
    chk("t1_go_t0", 64'(dma_rd_go), 64'd0);
    tick();
    ch_rd_go = '0;
    #1;
    chk("t1_busy", 64'(ch_rd_busy), 64'h2);
    chk("t1_go_t1", 64'(dma_rd_go), 64'd0);
    tick();
    chk("t1_go_t2", 64'(dma_rd_go), 64'd1);
    chk("t1_addr", 64'(dma_rd_addr), 64'h1040);
    chk("t1_size", 64'(dma_rd_size), 64'd8);
    tick();
    dma_empty = 1'b0;
    dma_rd_data = 32'hABCD_1234;
    ch_rd_en = 4'b0101;
    #1;
    chk("t1_go_once", 64'(dma_rd_go), 64'd0);
    chk("t1_addr_hold", 64'(dma_rd_addr), 64'h1040);
    chk("t5_en_other", 64'(dma_rd_en), 64'd0);
    chk("t5_empty", 64'(ch_empty), 64'hD);
    chk("t5_data", 64'(ch_rd_data), 64'hABCD_1234);
    ch_rd_en = 4'b0010;
    #1;
    chk("t5_en_own", 64'(dma_rd_en), 64'd1);
    ch_rd_en = '0;
    dma_empty = 1'b1;
    dma_rd_done = 1'b1;
    tick();
    dma_rd_done = 1'b0;
    #1;
    chk("t1_done", 64'(ch_rd_done), 64'h2);
    chk("t1_busy_done", 64'(ch_rd_busy), 64'h2);
    tick();
    chk("t1_done_pulse", 64'(ch_rd_done), 64'h0);
    chk("t1_busy_clr", 64'(ch_rd_busy), 64'h0);
    // busy go and size-zero go are both rejected
    ch_rd_go = 4'b0100;
    tick();
    #1;
    chk("t3_err_none", 64'(ch_rd_err), 64'h0);
    tick();
    ch_rd_go = '0;
    #1;
    chk("t3_err_busy", 64'(ch_rd_err), 64'h4);
    serve_rd("t3", 32'h1030, 4'b0100);
    count_gos(4);
    chk("t3_one_xfer", 64'(gos), 64'd0);
    ch_rd_size[31:16] = 16'd0;
    ch_rd_go = 4'b0010;
    tick();
    ch_rd_go = '0;
    #1;
    chk("t3_err_size0", 64'(ch_rd_err), 64'h2);
    chk("t3_busy_size0", 64'(ch_rd_busy), 64'h0);
    count_gos(4);
    chk("t3_no_go", 64'(gos), 64'd0);
    ch_rd_size[31:16] = 16'd8;
    // wrapping base address, concurrent read and write
    base_addr = 32'hFFFF_FFF0;
    ch_wr_go = 4'b0001;
    ch_rd_go = 4'b1000;
    tick();
    ch_wr_go = '0;
    ch_rd_go = '0;
    tick();
    chk("t4_both_go", 64'({dma_rd_go, dma_wr_go}), 64'h3);
    chk("t4_wr_addr", 64'(dma_wr_addr), 64'h10);
    chk("t4_wr_size", 64'(dma_wr_size), 64'd4);
    chk("t4_rd_addr", 64'(dma_rd_addr), 64'h30);
    tick();
    ch_wr_data[31:0] = 32'h55AA_33CC;
    ch_wr_en = 4'b0001;
    dma_full = 1'b0;
    #1;
    chk("t4_wr_data", 64'(dma_wr_data), 64'h55AA_33CC);
    chk("t4_wr_en", 64'(dma_wr_en), 64'd1);
    chk("t4_full", 64'(ch_full), 64'hE);
    ch_wr_en = '0;
    dma_full = 1'b1;
    dma_rd_done = 1'b1;
    dma_wr_done = 1'b1;
    tick();
    dma_rd_done = 1'b0;
    dma_wr_done = 1'b0;
    #1;
    chk("t4_done", 64'({ch_rd_done, ch_wr_done}), 64'h81);
    tick();
    // reset in ACTIVE abandons the transfer
    base_addr = 32'h1000;
    ch_rd_go = 4'b0010;
    tick();
    ch_rd_go = '0;
    tick();
    tick();
    dma_rd_done = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_busy", 64'(ch_rd_busy), 64'h0);
    chk("t6_empty", 64'(ch_empty), 64'hF);
    chk("t6_pulses", 64'({ch_rd_done, ch_rd_err, 3'b0, dma_rd_go}), 64'h0);
    chk("t6_addr", 64'(dma_rd_addr), 64'h0);
    tick();
    dma_rd_done = 1'b0;
    #1;
    chk("t6_no_done", 64'(ch_rd_done), 64'h0);
    ch_rd_go = 4'b1111;
    tick();
    ch_rd_go = '0;
    serve_rd("t6_ch0", 32'h1010, 4'b0001);
    serve_rd("t6_ch1", 32'h1040, 4'b0010);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
